// File: rtl/layer_serializer.sv
// layer_serializer: captures one frame of NUM_NEURONS parallel neuron outputs and
// replays it one word per cycle, in neuron order, to the next layer's serial input.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   x_in       parallel words, word i at x_in[i*DATAWIDTH +: DATAWIDTH]
//   in_valid   per-neuron valid pulses; a capture is requested when they fire
//   out_val    serial word, zero whenever out_valid is low
//   out_valid  qualifies out_val
//   busy       high while a frame is being emitted
//   overrun    sticky: a capture request arrived mid-frame and was dropped
//   valid_err  sticky: partial in_valid pattern seen (VALID_CHECK_EN builds only)
//
// Build option: define VALID_CHECK_EN to require all in_valid bits for a capture
// and to flag partial patterns; otherwise in_valid[0] alone requests a capture.
module layer_serializer #(
    parameter int unsigned NUM_NEURONS = 30,
    parameter int unsigned DATAWIDTH   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATAWIDTH*NUM_NEURONS-1:0] x_in,
    input  logic [NUM_NEURONS-1:0]         in_valid,
    output logic [DATAWIDTH-1:0]           out_val,
    output logic                           out_valid,
    output logic                           busy,
    output logic                           overrun,
    output logic                           valid_err
);

    localparam int unsigned CNT_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_NEURONS - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t               state_q, state_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic [DATAWIDTH-1:0] words_q [NUM_NEURONS];
    logic [DATAWIDTH-1:0] out_val_n;
    logic                 out_valid_n;
    logic                 busy_n;
    logic                 overrun_n;
    logic                 load;
    logic                 cap;

`ifdef VALID_CHECK_EN
    logic partial;

    // Only a full frame is captured; any other non-zero pattern is an error.
    assign cap     = &in_valid;
    assign partial = (|in_valid) & ~cap;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_err <= 1'b0;
        end else if (partial) begin
            valid_err <= 1'b1;
        end
    end
`else
    logic unused_valid_bits;

    // Neuron 0 stands in for the whole layer; the other valid bits are ignored.
    assign cap               = in_valid[0];
    assign unused_valid_bits = ^in_valid;
    assign valid_err         = 1'b0;
`endif

    // Next-state and next-output logic; cnt_q is the index of the word on out_val.
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        out_val_n   = '0;
        out_valid_n = 1'b0;
        busy_n      = 1'b0;
        overrun_n   = overrun;
        load        = 1'b0;

        if (state_q == SHIFT && cnt_q != LAST_IDX) begin
            // Mid-frame: advance; a capture request here is dropped.
            cnt_n       = cnt_q + CNT_W'(1);
            out_val_n   = words_q[cnt_n];
            out_valid_n = 1'b1;
            busy_n      = 1'b1;
            if (cap) begin
                overrun_n = 1'b1;
            end
        end else if (cap) begin
            // Idle or last word: start a frame, word 0 comes straight from x_in.
            load        = 1'b1;
            state_n     = SHIFT;
            cnt_n       = '0;
            out_val_n   = x_in[DATAWIDTH-1:0];
            out_valid_n = 1'b1;
            busy_n      = 1'b1;
        end else begin
            state_n = IDLE;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            out_val   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            out_val   <= out_val_n;
            out_valid <= out_valid_n;
            busy      <= busy_n;
            overrun   <= overrun_n;
        end
    end

    // Frame buffer; contents are irrelevant until the first capture.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                words_q[i] <= x_in[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

endmodule
